// File: rtl/pixel_streamer.sv
// Frame pixel streamer: walks a synchronous RAM in raster order and emits each pixel
// through a fixed 2-stage pipeline, with optional idle cycles after every row.
module pixel_streamer #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int PIX_W  = 12,
    parameter int HBLANK = 0,
    // held at 1 bit for a 1x1 frame so the address port never collapses to zero width
    parameter int ADDR_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              out_ready,
    output logic              frame_start,
    output logic              line_end,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] BLANK  = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BL_W  = (HBLANK > 1) ? $clog2(HBLANK) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [BL_W-1:0]   BL_LAST   = BL_W'((HBLANK > 0) ? HBLANK - 1 : 0);

    logic [1:0]        state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic [BL_W-1:0]   blank_cnt;

    logic v1, fs1, le1, fd1;

    assign mem_rd_en = (state == STREAM) && !pause;
    assign mem_addr  = addr;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            addr      <= '0;
            blank_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= STREAM;
                end
                STREAM: begin
                    if (!pause) begin
                        if (col == COL_LAST) begin
                            if (row == ROW_LAST) begin
                                // address stays on the last pixel until the drain completes
                                state <= DRAIN;
                            end else begin
                                col  <= '0;
                                row  <= row + 1'b1;
                                addr <= addr + 1'b1;
                                if (HBLANK > 0) begin
                                    state     <= BLANK;
                                    blank_cnt <= '0;
                                end
                            end
                        end else begin
                            col  <= col + 1'b1;
                            addr <= addr + 1'b1;
                        end
                    end
                end
                BLANK: begin
                    if (blank_cnt == BL_LAST) state <= STREAM;
                    else                      blank_cnt <= blank_cnt + 1'b1;
                end
                default: begin
                    if (out_ready && frame_done) begin
                        state <= IDLE;
                        col   <= '0;
                        row   <= '0;
                        addr  <= '0;
                    end
                end
            endcase
        end
    end

    // flags are computed from the read address, so gaps never shift them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1          <= 1'b0;
            fs1         <= 1'b0;
            le1         <= 1'b0;
            fd1         <= 1'b0;
            out_ready   <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_done  <= 1'b0;
            pixel_out   <= '0;
        end else begin
            v1          <= mem_rd_en;
            fs1         <= mem_rd_en && (addr == '0);
            le1         <= mem_rd_en && (col == COL_LAST);
            fd1         <= mem_rd_en && (addr == ADDR_LAST);
            out_ready   <= v1;
            frame_start <= fs1;
            line_end    <= le1;
            frame_done  <= fd1;
            if (v1) pixel_out <= mem_rd_data;
        end
    end

endmodule
